// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrated mux with valid/ready handshakes and a one-entry output register.
// Define RR_ARB_MUX_TRISTATE_EN to drive out_data through bufif1 gated by out_valid.
module rr_arb_mux #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  output logic [N_CH-1:0]         in_ready,
  output logic                    out_valid,
`ifdef RR_ARB_MUX_TRISTATE_EN
  output wire  [WIDTH-1:0]        out_data,
`else
  output logic [WIDTH-1:0]        out_data,
`endif
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready
);

  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   r_last;

  logic [N_CH-1:0]   w_grant;
  logic              w_found;
  logic [CH_W-1:0]   w_grant_idx;
  logic [WIDTH-1:0]  w_grant_data;
  logic              w_load;

  // Search starts one past the last winner and wraps, so the winner drops to lowest priority.
  always_comb begin
    logic [CH_W-1:0] w_idx;
    w_grant     = '0;
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_idx       = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      w_idx = CH_W'((32'(r_last) + k) % N_CH);
      if (!w_found && in_valid[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_grant_idx    = w_idx;
      end
    end
  end

  always_comb begin
    w_grant_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_grant[i]) begin
        w_grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_load = ~r_valid | out_ready;

  // Masking with rst keeps producers from seeing an accept that the reset will discard.
  assign in_ready = w_grant & {N_CH{w_load & ~rst}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_last  <= CH_W'(N_CH - 1);
    end else if (w_load) begin
      r_valid <= w_found;
      if (w_found) begin
        r_data <= w_grant_data;
        r_ch   <= w_grant_idx;
        r_last <= w_grant_idx;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_ch    = r_ch;

`ifdef RR_ARB_MUX_TRISTATE_EN
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tri
    bufif1 u_buf (out_data[gi], r_data[gi], r_valid);
  end
`else
  assign out_data = r_data;
`endif

endmodule
